// File: rtl/uart_prog_loader.sv
// UART program loader: receives a SYNC/COUNT/payload/CHK frame and writes each
// payload byte into nibble-wide program memory while holding the CPU in reset.
module uart_prog_loader #(
   parameter int         MEM_ADDR_WIDTH = 5,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 65535,
   parameter int         TIMEOUT_WIDTH  = 16
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [7:0]                rx_data_i,
   input  logic                      rx_valid_i,
   output logic                      mem_we_o,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
   output logic [3:0]                mem_data_o,
   output logic                      cpu_hold_o,
   output logic                      load_done_o,
   output logic                      load_err_o
);

   localparam int MAX_COUNT = 2 ** (MEM_ADDR_WIDTH - 1);
   localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COUNT,
      ST_DATA,
      ST_WR_LO,
      ST_WR_HI,
      ST_CHECK
   } state_t;

   state_t                    state_reg, state_next;
   logic [MEM_ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic [MEM_ADDR_WIDTH-1:0] count_reg, count_next;
   logic [MEM_ADDR_WIDTH-1:0] bytes_reg, bytes_next;
   logic [7:0]                chk_reg, chk_next;
   logic [7:0]                byte_reg, byte_next;
   logic [TIMEOUT_WIDTH-1:0]  timeout_reg, timeout_next;
   logic                      hold_reg, hold_next;
   logic                      err_reg, err_next;
   logic                      done_reg, done_next;
   logic                      wait_state;
   logic                      timed_out;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_reg   <= ST_IDLE;
         addr_reg    <= '0;
         count_reg   <= '0;
         bytes_reg   <= '0;
         chk_reg     <= '0;
         byte_reg    <= '0;
         timeout_reg <= '0;
         hold_reg    <= 1'b0;
         err_reg     <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         addr_reg    <= addr_next;
         count_reg   <= count_next;
         bytes_reg   <= bytes_next;
         chk_reg     <= chk_next;
         byte_reg    <= byte_next;
         timeout_reg <= timeout_next;
         hold_reg    <= hold_next;
         err_reg     <= err_next;
         done_reg    <= done_next;
      end
   end

   // Timeout fires on the TIMEOUT_CYCLES-th consecutive silent cycle of a waiting state.
   assign wait_state = (state_reg == ST_COUNT) || (state_reg == ST_DATA) || (state_reg == ST_CHECK);
   assign timed_out  = wait_state && !rx_valid_i && (timeout_reg == TIMEOUT_LAST);

   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      count_next = count_reg;
      bytes_next = bytes_reg;
      chk_next   = chk_reg;
      byte_next  = byte_reg;
      hold_next  = hold_reg;
      err_next   = err_reg;
      done_next  = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (rx_valid_i && rx_data_i == SYNC_BYTE) begin
               state_next = ST_COUNT;
               hold_next  = 1'b1;
               err_next   = 1'b0;
               addr_next  = '0;
               bytes_next = '0;
               chk_next   = '0;
            end
         end
         ST_COUNT: begin
            if (rx_valid_i) begin
               chk_next   = rx_data_i;
               count_next = rx_data_i[MEM_ADDR_WIDTH-1:0];
               if (rx_data_i != 8'd0 && rx_data_i <= 8'(MAX_COUNT)) begin
                  state_next = ST_DATA;
               end else begin
                  state_next = ST_IDLE;
                  err_next   = 1'b1;
                  hold_next  = 1'b0;
               end
            end
         end
         ST_DATA: begin
            if (rx_valid_i) begin
               byte_next  = rx_data_i;
               chk_next   = chk_reg + rx_data_i;
               bytes_next = bytes_reg + MEM_ADDR_WIDTH'(1);
               state_next = ST_WR_LO;
            end
         end
         ST_WR_LO: begin
            addr_next  = addr_reg + MEM_ADDR_WIDTH'(1);
            state_next = ST_WR_HI;
            if (rx_valid_i) err_next = 1'b1;
         end
         ST_WR_HI: begin
            addr_next  = addr_reg + MEM_ADDR_WIDTH'(1);
            state_next = (bytes_reg == count_reg) ? ST_CHECK : ST_DATA;
            if (rx_valid_i) err_next = 1'b1;
         end
         ST_CHECK: begin
            if (rx_valid_i) begin
               state_next = ST_IDLE;
               hold_next  = 1'b0;
               if (rx_data_i == chk_reg) done_next = 1'b1;
               else err_next = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      if (timed_out) begin
         state_next = ST_IDLE;
         err_next   = 1'b1;
         hold_next  = 1'b0;
      end

      // Counter restarts on any strobe and on every state change.
      if (wait_state && !rx_valid_i && state_next == state_reg)
         timeout_next = timeout_reg + TIMEOUT_WIDTH'(1);
      else
         timeout_next = '0;
   end

   assign mem_we_o    = (state_reg == ST_WR_LO) || (state_reg == ST_WR_HI);
   assign mem_addr_o  = addr_reg;
   assign mem_data_o  = (state_reg == ST_WR_LO) ? byte_reg[3:0] :
                        (state_reg == ST_WR_HI) ? byte_reg[7:4] : 4'h0;
   assign cpu_hold_o  = hold_reg;
   assign load_done_o = done_reg;
   assign load_err_o  = err_reg;

endmodule

// File: doc/uart_prog_loader.md
UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 Parameter MEM_ADDR_WIDTH, default 5: nibble program-memory address width (32 words).
REQ-002 Parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-003 Parameter TIMEOUT_CYCLES, default 65535: maximum idle clk_i cycles between bytes inside a frame.
REQ-004 Parameter TIMEOUT_WIDTH, default 16: timeout counter width.
REQ-005 clk_i  input  1  clock; all state changes on rising edge.
REQ-006 reset_i  input  1  reset, asynchronous, active-high.
REQ-007 rx_data_i  input  8  received byte from the upstream UART receiver; valid only while rx_valid_i=1.
REQ-008 rx_valid_i  input  1  single-cycle byte-valid strobe from the receiver.
REQ-009 mem_we_o  output  1  program-memory write enable, one cycle per nibble.
REQ-010 mem_addr_o  output  MEM_ADDR_WIDTH  program-memory write address.
REQ-011 mem_data_o  output  4  program-memory write data.
REQ-012 cpu_hold_o  output  1  holds the CPU in reset while a frame is being loaded.
REQ-013 load_done_o  output  1  one-cycle pulse on a successful frame.
REQ-014 load_err_o  output  1  sticky error flag.

Function
REQ-015 Frame format SHALL be: SYNC_BYTE, COUNT, COUNT payload bytes, CHK. CHK is the 8-bit sum mod 256 of COUNT and all payload bytes.
REQ-016 The block SHALL have states IDLE, COUNT, DATA, WR_LO, WR_HI and CHECK.
REQ-017 IDLE: an rx_valid_i with rx_data_i==SYNC_BYTE SHALL go to COUNT, set cpu_hold_o=1, clear load_err_o, and zero the address, byte counter and checksum. Any other byte SHALL be ignored.
REQ-018 COUNT: a strobe SHALL latch COUNT and set checksum=COUNT.
  - COUNT in 1..2^(MEM_ADDR_WIDTH-1): go to DATA.
  - Otherwise: set load_err_o, drop cpu_hold_o, go to IDLE.
REQ-019 DATA: a strobe SHALL register the byte, add it to the checksum, increment the byte counter and go to WR_LO.
REQ-020 WR_LO (one cycle): mem_we_o=1, mem_data_o=byte[3:0], mem_addr_o=addr; then addr+1 and go to WR_HI.
REQ-021 WR_HI (one cycle): mem_we_o=1, mem_data_o=byte[7:4], mem_addr_o=addr; then addr+1. Go to CHECK if byte counter==COUNT, else go to DATA.
REQ-022 Address arithmetic SHALL wrap modulo 2^MEM_ADDR_WIDTH. The checksum SHALL wrap modulo 256.
REQ-023 CHECK: a strobe SHALL compare rx_data_i with the checksum, go to IDLE and drop cpu_hold_o.
  - Match: pulse load_done_o the next cycle.
  - Mismatch: set load_err_o.
REQ-024 An rx_valid_i arriving in WR_LO or WR_HI SHALL be dropped and SHALL set load_err_o. The frame SHALL continue.
REQ-025 In COUNT, DATA and CHECK, the timeout counter SHALL reset on every strobe and on every state entry.
REQ-026 When the timeout counter reaches TIMEOUT_CYCLES: set load_err_o, drop cpu_hold_o, go to IDLE.
REQ-027 A SYNC_BYTE received mid-frame SHALL be treated as ordinary data. There is no resynchronisation.
REQ-028 mem_we_o SHALL be 0 in every state except WR_LO and WR_HI.
REQ-029 load_done_o and load_err_o SHALL never both be asserted by the same frame's CHECK.

Reset
REQ-030 While reset_i=1, the block SHALL be held in IDLE.
REQ-031 Reset SHALL zero every counter, the checksum and the byte register, and drive all outputs to 0, including cpu_hold_o.
REQ-032 Asserting reset mid-frame SHALL abandon the frame without any further memory write.

Verification
REQ-033 Frame A5,02,21,43,CHK=66 -> writes (0,1),(1,2),(2,3),(3,4); one load_done_o pulse; load_err_o=0; cpu_hold_o high from SYNC to CHECK.
REQ-034 Frame A5,01,FF,CHK=00 -> writes (0,F),(1,F); load_done_o pulse; the checksum wraps correctly.
REQ-035 Frame A5,01,12,CHK=99 -> writes (0,2),(1,1); load_err_o=1; no load_done_o; cpu_hold_o falls.
REQ-036 A5,00 -> load_err_o=1, no writes, back to IDLE. A following valid frame loads correctly and clears load_err_o at its SYNC.
REQ-037 A5,03,11 then TIMEOUT_CYCLES silent cycles -> load_err_o=1, IDLE, cpu_hold_o=0.
REQ-038 reset_i pulsed between payload bytes -> all outputs 0 immediately and no further mem_we_o. Bytes 7E,A5 received in IDLE -> only A5 starts a frame.
